alu16_seq: RTL and testbench

- Sequencer that drives the operand side of the 16-bit `alu16` (A, B, Op, Cin) and captures its outputs (Y, Cout).
- Executes one wide operation of NWORDS×16 bits as NWORDS consecutive single-cycle ALU passes, least significant word first.
- Carry is chained between passes for carry-propagating ops.
- Sits between a command producer (valid/ready) and a result consumer (valid/ready); `alu16` stays combinational and external.

---
 rtl/alu16_seq_if.sv | 40 ++++
 rtl/alu16_seq.sv | 111 +++++++++++
 tb/tb_alu16_seq.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu16_seq_if.sv
// Bundle of command, ALU-operand and response signals around the alu16 word sequencer.
// slave is the sequencer's view; master is the producer/ALU/consumer side.
interface alu16_seq_if #(
    parameter int unsigned NWORDS = 2
);
    localparam int unsigned W = 16 * NWORDS;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic           cmd_cin;

    logic [15:0]    alu_a;
    logic [15:0]    alu_b;
    logic [2:0]     alu_op;
    logic           alu_cin;
    logic [15:0]    alu_y;
    logic           alu_cout;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_y;
    logic           rsp_cout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin,
        input  alu_y, alu_cout, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, alu_cin,
        output rsp_valid, rsp_y, rsp_cout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin,
        output alu_y, alu_cout, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, alu_cin,
        input  rsp_valid, rsp_y, rsp_cout
    );
endinterface

// File: rtl/alu16_seq.sv
// Runs one NWORDS x 16-bit operation through an external combinational alu16,
// one word per cycle, LSW first, chaining carry for ops selected by CHAIN_MASK.
module alu16_seq #(
    parameter int unsigned NWORDS     = 2,
    parameter logic [7:0]  CHAIN_MASK = 8'b0010_0001
) (
    input  logic       clk,
    input  logic       rst_n,
    alu16_seq_if.slave bus
);
    localparam int unsigned W  = 16 * NWORDS;
    localparam int unsigned CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, RSP} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_i;
    logic [2:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_cin;
    logic            r_carry;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_rsp_y;
    logic            r_rsp_cout;
    logic            r_cmd_ready;
    logic            r_rsp_valid;

    logic [CW+3:0]   w_base;
    logic            w_cin;
    logic [W-1:0]    w_acc_next;

    always_comb begin
        w_base     = {r_i, 4'b0000};
        w_cin      = (r_i == '0 || !CHAIN_MASK[r_op]) ? r_cin : r_carry;
        w_acc_next = r_acc;
        w_acc_next[w_base +: 16] = bus.alu_y;

        bus.alu_a   = '0;
        bus.alu_b   = '0;
        bus.alu_op  = '0;
        bus.alu_cin = 1'b0;
        if (r_state == RUN) begin
            bus.alu_a   = r_a[w_base +: 16];
            bus.alu_b   = r_b[w_base +: 16];
            bus.alu_op  = r_op;
            bus.alu_cin = w_cin;
        end
    end

    // Partial words build up in r_acc so rsp_y only changes when a full result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_carry     <= 1'b0;
            r_acc       <= '0;
            r_rsp_y     <= '0;
            r_rsp_cout  <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_op        <= bus.cmd_op;
                        r_a         <= bus.cmd_a;
                        r_b         <= bus.cmd_b;
                        r_cin       <= bus.cmd_cin;
                        r_i         <= '0;
                        r_carry     <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= RUN;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= bus.alu_cout;
                    if (r_i == LAST) begin
                        r_rsp_y     <= w_acc_next;
                        r_rsp_cout  <= bus.alu_cout;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RSP;
                    end else begin
                        r_i <= r_i + CW'(1);
                    end
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.rsp_cout  = r_rsp_cout;
endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: behavioural alu16, wide-arithmetic result model checked every
// cycle, plus directed vectors with hand-computed literals.
module tb_alu16_seq;
    localparam int unsigned NW   = 2;
    localparam int unsigned W    = 16 * NW;
    localparam logic [7:0]  MASK = 8'b0010_0001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    alu16_seq_if #(.NWORDS(NW)) bus();

    alu16_seq #(.NWORDS(NW), .CHAIN_MASK(MASK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {cout, y} of the external 16-bit ALU
    function automatic logic [16:0] alu16_f(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b} + {16'd0, c};
            3'd1:    return {1'b0, a} + {1'b0, ~b} + {16'd0, c};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a, c};
            3'd6:    return {a[0], c, a[15:1]};
            default: return {c, a};
        endcase
    endfunction

    always_comb {bus.alu_cout, bus.alu_y} = alu16_f(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cin);

    // Whole-width result: chained ops are plain wide arithmetic; others are independent words.
    function automatic logic [W:0] model_res(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic cin);
        logic [W-1:0] r;
        logic [16:0]  p;
        logic         c;
        if (MASK[op] && op == 3'd0) return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        if (MASK[op] && op == 3'd5) return {a, cin};
        r = '0;
        c = 1'b0;
        for (int k = 0; k < int'(NW); k++) begin
            p = alu16_f(op, a[16*k +: 16], b[16*k +: 16], cin);
            r[16*k +: 16] = p[15:0];
            c = p[16];
        end
        return {c, r};
    endfunction

    function automatic logic exp_cin(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic cin, input int k);
        logic [W:0] lm;
        logic [W:0] s;
        if (k == 0 || !MASK[op]) return cin;
        if (op == 3'd5) return a[16*k-1];
        lm = ({{W{1'b0}}, 1'b1} << (16*k)) - 1'b1;
        s  = ({1'b0, a} & lm) + ({1'b0, b} & lm) + {{W{1'b0}}, cin};
        return s[16*k];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: timeout at %0t", name, $time);
    endtask

    logic         m_ready = 1'b0;
    logic         m_valid = 1'b0;
    int           m_cnt   = 0;
    logic [2:0]   m_op    = '0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    logic         m_cin   = 1'b0;
    logic [W-1:0] m_y     = '0;
    logic         m_cout  = 1'b0;
    logic [W:0]   m_pend  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_y     <= '0;
            m_cout  <= 1'b0;
        end else if (m_valid) begin
            if (bus.rsp_ready) begin
                m_valid <= 1'b0;
                m_ready <= 1'b1;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid         <= 1'b1;
                {m_cout, m_y}   <= m_pend;
            end
        end else if (m_ready && bus.cmd_valid) begin
            m_ready <= 1'b0;
            m_cnt   <= int'(NW);
            m_op    <= bus.cmd_op;
            m_a     <= bus.cmd_a;
            m_b     <= bus.cmd_b;
            m_cin   <= bus.cmd_cin;
            m_pend  <= model_res(bus.cmd_op, bus.cmd_a, bus.cmd_b, bus.cmd_cin);
        end else begin
            m_ready <= 1'b1;
        end
    end

    logic cap_cin  [NW];
    logic cap_cout [NW];

    always @(negedge clk) begin
        int k;
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(m_ready));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
        chk("rsp_y",     64'(bus.rsp_y),     64'(m_y));
        chk("rsp_cout",  64'(bus.rsp_cout),  64'(m_cout));
        chk("ready_and_valid", 64'(bus.cmd_ready & bus.rsp_valid), 64'd0);
        if (m_cnt > 0) begin
            k = int'(NW) - m_cnt;
            chk("alu_a",   64'(bus.alu_a),   64'(m_a[16*k +: 16]));
            chk("alu_b",   64'(bus.alu_b),   64'(m_b[16*k +: 16]));
            chk("alu_op",  64'(bus.alu_op),  64'(m_op));
            chk("alu_cin", 64'(bus.alu_cin), 64'(exp_cin(m_op, m_a, m_b, m_cin, k)));
            cap_cin[k]  = bus.alu_cin;
            cap_cout[k] = bus.alu_cout;
        end else begin
            chk("alu_idle", {27'd0, bus.alu_cin, bus.alu_op, bus.alu_a, bus.alu_b}, 64'd0);
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
        int t;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_cin   = cin;
        bus.cmd_valid = 1'b1;
        t = 0;
        while (!bus.cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) begin
            timeout("accept");
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~op;
        bus.cmd_a     = ~a;
        bus.cmd_b     = ~b;
        bus.cmd_cin   = ~cin;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        if (!bus.rsp_valid) timeout("rsp_valid");
    endtask

    task automatic take();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_cin   = 1'b0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_rsp_y",     64'(bus.rsp_y),     64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // abort mid-RUN: assert reset during the second word pass
        send(3'd0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("abort_rsp_y",     64'(bus.rsp_y),     64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_back", 64'(bus.cmd_ready), 64'd1);
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", 64'(bus.rsp_valid), 64'd0);

        send(3'd0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
        wait_rsp(lat);
        chk("add_latency", 64'(lat), 64'd2);
        chk("add_cin1",    64'(cap_cin[1]), 64'd1);
        chk("add_y",       64'(bus.rsp_y), 64'h0001_0000);
        chk("add_cout",    64'(bus.rsp_cout), 64'd0);
        take();

        send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_rsp(lat);
        chk("ovf_y",    64'(bus.rsp_y), 64'h0000_0000);
        chk("ovf_cout", 64'(bus.rsp_cout), 64'd1);
        take();

        send(3'd2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        wait_rsp(lat);
        chk("and_cin0", 64'(cap_cin[0]), 64'd1);
        chk("and_cin1", 64'(cap_cin[1]), 64'd1);
        chk("and_y",    64'(bus.rsp_y), 64'h1234_5678);
        take();

        send(3'd5, 32'h8080_8080, 32'h0000_0000, 1'b0);
        wait_rsp(lat);
        chk("shl_cout0", 64'(cap_cout[0]), 64'd1);
        chk("shl_cin1",  64'(cap_cin[1]),  64'(cap_cout[0]));
        chk("shl_y",     64'(bus.rsp_y), 64'h0101_0100);
        chk("shl_cout",  64'(bus.rsp_cout), 64'd1);
        take();

        // backpressure with the next command already waiting
        send(3'd0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        wait_rsp(lat);
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 32'hFFFF_0000;
        bus.cmd_b     = 32'h0001_0000;
        bus.cmd_cin   = 1'b0;
        bus.cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_y",     64'(bus.rsp_y), 64'h2345_678A);
            chk("bp_cout",  64'(bus.rsp_cout), 64'd0);
            chk("bp_ready", 64'(bus.cmd_ready), 64'd0);
        end
        #1;
        take();
        chk("bp_ready_after", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        chk("bp_accepted", 64'(bus.cmd_ready), 64'd0);
        wait_rsp(lat);
        chk("bp2_latency", 64'(lat), 64'd2);
        chk("bp2_y",       64'(bus.rsp_y), 64'h0000_0000);
        chk("bp2_cout",    64'(bus.rsp_cout), 64'd1);
        take();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
